// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU / mul-div unit: op codes, FSM states, decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_AND    = 5'h02,
    OP_OR     = 5'h03,
    OP_XOR    = 5'h04,
    OP_SLL    = 5'h05,
    OP_SRL    = 5'h06,
    OP_SRA    = 5'h07,
    OP_SLT    = 5'h08,
    OP_SLTU   = 5'h09,
    OP_XNOR   = 5'h0A,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_e;

  // Per-operation control captured when an iterative op is accepted.
  typedef struct packed {
    alu_op_e op;
    logic    neg_res;  // negate product / quotient at the end
    logic    neg_rem;  // negate remainder at the end (follows dividend sign)
  } md_ctl_t;

  // Any of 0x10..0x17.
  function automatic logic is_md_op(alu_op_e op);
    logic [4:0] code;
    code = op;
    return code[4:3] == 2'b10;
  endfunction

  // 0x10..0x13.
  function automatic logic is_mul_op(alu_op_e op);
    logic [4:0] code;
    code = op;
    return code[4:2] == 3'b100;
  endfunction

  // 0x14..0x17.
  function automatic logic is_div_op(alu_op_e op);
    logic [4:0] code;
    code = op;
    return code[4:2] == 3'b101;
  endfunction

  function automatic logic src1_signed(alu_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic src2_signed(alu_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational integer ALU for op codes 0x00..0x0A; any other code yields 0.
// Latency: 0 (combinational).
// Backpressure: none; the caller registers the result.
// Ports: op (5-bit code), a/b (operands), y (result).
module alu_core
  import alu_pkg::*;
#(
  parameter int OP_W = 32
) (
  input  logic [4:0]      op,
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [OP_W-1:0] y
);

  localparam int SH_W = $clog2(OP_W);

  // Shift amount is only the low SH_W bits of b; upper bits are ignored.
  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << shamt;
      OP_SRL:  y = a >> shamt;
      OP_SRA:  y = $unsigned($signed(a) >>> shamt);
      OP_SLT:  y = {{(OP_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: y = {{(OP_W-1){1'b0}}, (a < b)};
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU plus iterative RV32M-style mul/div/rem behind valid/ready handshakes.
// Latency: ALU ops write the result at the accepting edge; mul/div take OP_W+1 further edges.
// Backpressure: in_ready drops while mul/div runs or a held result is not being accepted.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/op/src1/src2 request side;
//        out_valid/out_ready/result response side; busy = iterative op in progress.
// Build option: define ALU_MDU_FAST_MUL_EN to compute MUL* with one combinational
//        multiplier in the single-cycle path; divide stays iterative either way.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int OP_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [OP_W-1:0] src1,
  input  logic [OP_W-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] result,
  output logic            busy
);

  localparam int SH_W  = $clog2(OP_W);
  localparam int CNT_W = SH_W + 1;

  mdu_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [2*OP_W-1:0] acc;   // {hi, lo}: mul = running product, div = {remainder, quotient}
  logic [OP_W-1:0]   opnd;  // mul = multiplicand magnitude, div = divisor magnitude
  md_ctl_t           ctl;

  alu_op_e op_e;
  assign op_e = alu_op_e'(op);

  logic fire, start_md, issue_alu, finish;
  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign busy      = (state != IDLE);
  assign fire      = in_valid && in_ready;
  assign issue_alu = fire && !start_md;
  assign finish    = (state != IDLE) && (cnt == '0);

  // Operand sign handling: magnitudes go into the datapath, signs are re-applied at the end.
  logic            neg1, neg2;
  logic [OP_W-1:0] mag1, mag2;
  assign neg1 = src1_signed(op_e) && src1[OP_W-1];
  assign neg2 = src2_signed(op_e) && src2[OP_W-1];
  assign mag1 = neg1 ? -src1 : src1;
  assign mag2 = neg2 ? -src2 : src2;

  // Single-cycle path.
  logic [OP_W-1:0] alu_y, one_res;

  alu_core #(.OP_W(OP_W)) u_alu_core (
    .op (op),
    .a  (src1),
    .b  (src2),
    .y  (alu_y)
  );

`ifdef ALU_MDU_FAST_MUL_EN
  logic [2*OP_W-1:0] fast_raw, fast_prod;
  assign fast_raw  = {{OP_W{1'b0}}, mag1} * {{OP_W{1'b0}}, mag2};
  assign fast_prod = (neg1 ^ neg2) ? -fast_raw : fast_raw;
  assign start_md  = fire && is_div_op(op_e);

  always_comb begin
    one_res = alu_y;
    if (is_mul_op(op_e)) begin
      one_res = (op_e == OP_MUL) ? fast_prod[OP_W-1:0] : fast_prod[2*OP_W-1:OP_W];
    end
  end
`else
  assign start_md = fire && is_md_op(op_e);
  assign one_res  = alu_y;
`endif

  // Shift-add step: add multiplicand into the high half when the current multiplier
  // bit (acc[0]) is set, then shift the whole {carry, hi, lo} right by one.
  logic [OP_W:0]     mul_sum;
  logic [2*OP_W-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*OP_W-1:OP_W]} + (acc[0] ? {1'b0, opnd} : {(OP_W+1){1'b0}});
  assign mul_next = {mul_sum, acc[OP_W-1:1]};

  // Restoring divide step: shift the next dividend bit into the partial remainder,
  // subtract the divisor if it fits. The remainder stays below the divisor, so the
  // kept value always fits in OP_W bits and a modulo-2^OP_W subtract is exact.
  logic [OP_W:0]     div_rem_sh;
  logic              div_ge;
  logic [OP_W-1:0]   div_hi;
  logic [2*OP_W-1:0] div_next;
  assign div_rem_sh = {acc[2*OP_W-1:OP_W], acc[OP_W-1]};
  assign div_ge     = div_rem_sh >= {1'b0, opnd};
  assign div_hi     = div_ge ? (div_rem_sh[OP_W-1:0] - opnd) : div_rem_sh[OP_W-1:0];
  assign div_next   = {div_hi, acc[OP_W-2:0], div_ge};

  // Final sign correction and half/quotient/remainder selection.
  logic [2*OP_W-1:0] prod_fin;
  logic [OP_W-1:0]   quot_fin, rem_fin, md_res;
  assign prod_fin = ctl.neg_res ? -acc : acc;
  assign quot_fin = ctl.neg_res ? -acc[OP_W-1:0] : acc[OP_W-1:0];
  assign rem_fin  = ctl.neg_rem ? -acc[2*OP_W-1:OP_W] : acc[2*OP_W-1:OP_W];

  always_comb begin
    md_res = rem_fin;
    case (ctl.op)
      OP_MUL:                      md_res = prod_fin[OP_W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod_fin[2*OP_W-1:OP_W];
      OP_DIV, OP_DIVU:             md_res = quot_fin;
      default:                     md_res = rem_fin;
    endcase
  end

  // FSM, counter and iterative datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      ctl   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_md) begin
            state   <= is_div_op(op_e) ? DIV : MUL;
            cnt     <= CNT_W'(OP_W);
            acc     <= {{OP_W{1'b0}}, (is_div_op(op_e) ? mag1 : mag2)};
            opnd    <= is_div_op(op_e) ? mag2 : mag1;
            ctl.op  <= op_e;
            // A zero divisor keeps the all-ones quotient unsigned-looking.
            ctl.neg_res <= is_div_op(op_e) ? ((neg1 ^ neg2) && (src2 != '0)) : (neg1 ^ neg2);
            ctl.neg_rem <= neg1;
          end
        end
        MUL, DIV: begin
          if (cnt != '0) begin
            acc <= (state == DIV) ? div_next : mul_next;
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result register. An ALU issue can coincide with acceptance of the previous result;
  // the new result then replaces it and out_valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (issue_alu) begin
      out_valid <= 1'b1;
      result    <= one_res;
    end else if (finish) begin
      out_valid <= 1'b1;
      result    <= md_res;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu (OP_W=32): directed corner cases then randomized traffic.
// Expected results come from a plain-arithmetic model; a monitor checks result, latency,
// busy and in_ready every cycle, independent of the stimulus process.
module tb_alu_mdu;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;

  alu_mdu #(.OP_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] res;
    int          xfer;
    int          lat;
    logic [4:0]  op;
    logic        md;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   cyc;
  int   rdy_mode;     // 0 = always ready, 1 = random, 2 = held low
  logic md_inflight;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model from the op definitions.
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [4:0]      sh;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sh  = b[4:0];
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      5'h00: return a + b;
      5'h01: return a - b;
      5'h02: return a & b;
      5'h03: return a | b;
      5'h04: return a ^ b;
      5'h05: return a << sh;
      5'h06: return a >> sh;
      5'h07: return $unsigned($signed(a) >>> sh);
      5'h08: return (sa < sb) ? 32'd1 : 32'd0;
      5'h09: return (a < b) ? 32'd1 : 32'd0;
      5'h0A: return ~(a ^ b);
      5'h10: begin p = 64'(ua * ub); return p[31:0]; end
      5'h11: begin p = 64'(sa * sb); return p[63:32]; end
      5'h12: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      5'h13: begin p = 64'(ua * ub); return p[63:32]; end
      5'h14: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      5'h15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'h16: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      5'h17: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic iter_op(input logic [4:0] o);
`ifdef ALU_MDU_FAST_MUL_EN
    return (o >= 5'h14) && (o <= 5'h17);
`else
    return (o >= 5'h10) && (o <= 5'h17);
`endif
  endfunction

  // Called just after a rising edge; returns after the edge that consumed the request.
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, output int xfer);
    int   waited;
    logic took;
    exp_t e;
    waited   = 0;
    took     = 1'b0;
    xfer     = -1;
    op       = o;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    while (!took && waited < 400) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!took) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: op=%h never accepted (got in_ready=0, want 1)", o);
    end else begin
      xfer   = cyc;
      e.res  = model(o, a, b);
      e.xfer = cyc;
      e.md   = iter_op(o);
      e.lat  = e.md ? (W + 1) : 0;
      e.op   = o;
      exp_q.push_back(e);
      if (e.md) md_inflight = 1'b1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Consumer-side ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: result on arrival, latency, stability while stalled, busy and in_ready.
  initial begin
    logic        prev_vld, prev_acc, held;
    logic [31:0] held_res;
    exp_t        e;
    prev_vld = 1'b0;
    prev_acc = 1'b0;
    held     = 1'b0;
    held_res = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld = 1'b0;
        prev_acc = 1'b0;
        held     = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_result", result, held_res);
        end
        if (out_valid && (!prev_vld || prev_acc)) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_result: got=%h with nothing outstanding", result);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("result_op%02h", e.op), result, e.res);
            chk($sformatf("latency_op%02h", e.op), 32'(cyc - e.xfer), 32'(e.lat));
            if (e.md) md_inflight = 1'b0;
          end
        end
        chk("busy", 32'(busy), 32'(md_inflight));
        chk("in_ready", 32'(in_ready), 32'(!md_inflight && (!out_valid || out_ready)));
        held     = out_valid && !out_ready;
        held_res = result;
        prev_vld = out_valid;
        prev_acc = out_valid && out_ready;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [4:0] codes [21] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                             5'h08, 5'h09, 5'h0A, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14,
                             5'h15, 5'h16, 5'h17, 5'h0B, 5'h1F};

  initial begin
    int x1, x2, g;
    total       = 0;
    bad         = 0;
    cyc         = 0;
    rdy_mode    = 0;
    md_inflight = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    op          = '0;
    src1        = '0;
    src2        = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back ALU ops: one per cycle.
    issue(5'h00, 32'd5, 32'hFFFF_FFF9, x1);
    issue(5'h00, 32'd100, 32'd23, x2);
    chk("b2b_gap", 32'(x2 - x1), 32'd1);

    // Multiply / divide corners.
    issue(5'h11, 32'h8000_0000, 32'h8000_0000, x1);
    issue(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, x1);
    issue(5'h14, 32'd7, 32'd0, x1);
    issue(5'h17, 32'd7, 32'd0, x1);
    issue(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, x1);
    issue(5'h16, 32'h8000_0000, 32'hFFFF_FFFF, x1);
    drain();

    // Output stall: SUB result held for 5 cycles; a pending ADD must not be consumed.
    rdy_mode  = 2;
    out_ready = 1'b0;
    issue(5'h01, 32'd3, 32'd3, x1);
    fork
      issue(5'h00, 32'd1, 32'd2, x2);
      begin
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    chk("stall_gap", 32'(x2 - x1), 32'd6);
    drain();

    // Reset in the middle of a divide.
    issue(5'h15, 32'hDEAD_BEEF, 32'd3, x1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", result, 32'd0);
    exp_q.delete();
    md_inflight = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(5'h05, 32'd1, 32'h25, x1);
    drain();

    // Randomized traffic with random consumer backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 250; i++) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      issue(codes[$urandom_range(0, 20)], pick_operand(), pick_operand(), x1);
    end
    rdy_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
